// File: rtl/pipe_pkg.sv
// Shared constants for the CPU inter-stage registers: payload widths,
// write-enable bit positions and performance-counter widths.
package pipe_pkg;

    localparam int RegAddrWidth = 5;
    localparam int RegDataWidth = 32;

    // target, ALU data, mem data, hi, lo concatenated by the instantiator
    localparam int MEM_WB_DATA_WIDTH = RegAddrWidth + 4 * RegDataWidth;
    localparam int EX_MEM_DATA_WIDTH = RegAddrWidth + 3 * RegDataWidth;

    localparam int PIPE_WE_WIDTH   = 4;
    localparam int WE_WRITEREG     = 0;
    localparam int WE_HI           = 1;
    localparam int WE_LO           = 2;
    localparam int WE_MEM_OR_ALU   = 3;

    localparam int STALL_CNT_W     = 32;
    localparam int FLUSH_CNT_W     = 16;

endpackage

// File: rtl/pipe_slot.sv
// One {valid, data, wen} holding register. Clear drops only the valid bit;
// data loads only when written.
module pipe_slot #(
    parameter int              DW         = 32,
    parameter int              WW         = 4,
    parameter logic [DW-1:0]   RESET_DATA = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_clr,
    input  logic [DW-1:0] i_d,
    input  logic [WW-1:0] i_w,
    output logic          o_v,
    output logic [DW-1:0] o_d,
    output logic [WW-1:0] o_w
);

    logic          r_v;
    logic [DW-1:0] r_d;
    logic [WW-1:0] r_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= 1'b0;
            r_d <= RESET_DATA;
            r_w <= '0;
        end else if (i_clr) begin
            r_v <= 1'b0;
        end else if (i_load) begin
            r_v <= 1'b1;
            r_d <= i_d;
            r_w <= i_w;
        end
    end

    assign o_v = r_v;
    assign o_d = r_d;
    assign o_w = r_w;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a 2-entry skid, hold and flush.
// Define PIPE_STAGE_PERF_CNT_EN to add saturating stall_cnt / flush_cnt outputs.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    WE_WIDTH   = PIPE_WE_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [WE_WIDTH-1:0]   in_wen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [WE_WIDTH-1:0]   out_wen,
`ifdef PIPE_STAGE_PERF_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [FLUSH_CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]            occ
);

    logic                  w_main_v, w_skid_v;
    logic [DATA_WIDTH-1:0] w_main_d, w_skid_d, w_main_din;
    logic [WE_WIDTH-1:0]   w_main_w, w_skid_w, w_main_win;
    logic                  w_acc, w_iss;
    logic                  w_main_load, w_main_clr, w_skid_load, w_skid_clr;

    // in_ready depends only on registered skid state, never on out_ready
    assign in_ready  = !rst && !hold && !flush && !w_skid_v;
    assign out_valid = w_main_v && !hold && !flush;
    assign w_acc     = in_valid && in_ready;
    assign w_iss     = out_valid && out_ready;

    // acc/iss are already zero under hold or flush, so only flush needs gating
    assign w_main_load = (w_skid_v && w_iss) || (w_acc && (!w_main_v || w_iss));
    assign w_main_clr  = flush || (w_iss && !w_acc && !w_skid_v);
    assign w_skid_load = w_acc && w_main_v && !w_iss;
    assign w_skid_clr  = flush || (w_skid_v && w_iss);

    assign w_main_din = w_skid_v ? w_skid_d : in_data;
    assign w_main_win = w_skid_v ? w_skid_w : in_wen;

    pipe_slot #(.DW(DATA_WIDTH), .WW(WE_WIDTH), .RESET_DATA(RESET_DATA)) u_main (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_main_load),
        .i_clr  (w_main_clr),
        .i_d    (w_main_din),
        .i_w    (w_main_win),
        .o_v    (w_main_v),
        .o_d    (w_main_d),
        .o_w    (w_main_w)
    );

    pipe_slot #(.DW(DATA_WIDTH), .WW(WE_WIDTH), .RESET_DATA(RESET_DATA)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_clr  (w_skid_clr),
        .i_d    (in_data),
        .i_w    (in_wen),
        .o_v    (w_skid_v),
        .o_d    (w_skid_d),
        .o_w    (w_skid_w)
    );

    assign out_data = w_main_d;
    assign out_wen  = out_valid ? w_main_w : '0;
    assign occ      = {1'b0, w_main_v} + {1'b0, w_skid_v};

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_main_v && !w_iss && !flush && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            if (flush && occ != 2'd0 && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + FLUSH_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and queue-model random checks for pipe_stage_reg.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int WW = 4;
    localparam logic [DW-1:0] RD = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst, hold, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [WW-1:0] in_wen, out_wen;
    logic [1:0]    occ;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0]   stall_cnt;
    logic [15:0]   flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_WIDTH(DW), .WE_WIDTH(WW), .RESET_DATA(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_wen    (in_wen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_wen   (out_wen),
`ifdef PIPE_STAGE_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .occ       (occ)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [WW-1:0] w,
                         input logic ordy, input logic h, input logic f);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_wen    = w;
        out_ready = ordy;
        hold      = h;
        flush     = f;
        #1;
    endtask

    logic [DW+WW-1:0] q[$];
    logic             ev_rdy, ev_ov;

    initial begin
        rst = 1'b1; hold = 0; flush = 0; in_valid = 0; out_ready = 0;
        in_data = '0; in_wen = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 0);
        chk("rst_occ",       occ, 0);
        chk("rst_out_data",  out_data, RD);
        chk("rst_out_wen",   out_wen, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Streaming
        for (int k = 0; k <= 8; k++) begin
            drive(k < 8, 32'h10 + k, 4'b1011, 1, 0, 0);
            chk("stream_in_ready", in_ready, 1);
            chk("stream_occ", occ, (k == 0) ? 0 : 1);
            if (k > 0) begin
                chk("stream_out_valid", out_valid, 1);
                chk("stream_out_data",  out_data, 32'h10 + k - 1);
                chk("stream_out_wen",   out_wen, 4'b1011);
            end
        end
        drive(0, 0, 0, 1, 0, 0);
        chk("stream_drain_occ", occ, 0);
        chk("stream_drain_wen", out_wen, 0);

        // Backpressure
        drive(1, 32'hA1, 4'h1, 0, 0, 0);
        drive(1, 32'hA2, 4'h2, 0, 0, 0);
        chk("bp_occ1", occ, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("bp_occ2", occ, 2);
        chk("bp_in_ready0", in_ready, 0);
        chk("bp_head", out_data, 32'hA1);
        drive(0, 0, 0, 1, 0, 0);
        chk("bp_first_data", out_data, 32'hA1);
        chk("bp_first_wen", out_wen, 4'h1);
        chk("bp_first_rdy", in_ready, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_data", out_data, 32'hA2);
        chk("bp_second_wen", out_wen, 4'h2);
        chk("bp_rdy_back", in_ready, 1);
        drive(0, 0, 0, 1, 0, 0);
        chk("bp_empty", occ, 0);

        // Hold
        drive(1, 32'h55, 4'hF, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h66, 4'hE, 1, 1, 0);
            chk("hold_out_valid", out_valid, 0);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_wen", out_wen, 0);
            chk("hold_occ", occ, 1);
        end
        drive(0, 0, 0, 1, 0, 0);
        chk("hold_rel_valid", out_valid, 1);
        chk("hold_rel_data", out_data, 32'h55);
        chk("hold_rel_wen", out_wen, 4'hF);
        drive(0, 0, 0, 1, 0, 0);
        chk("hold_rel_occ", occ, 0);

        // Flush with hold and in_valid
        drive(1, 32'hB1, 4'h3, 0, 0, 0);
        drive(1, 32'hB2, 4'h4, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("fl_occ2", occ, 2);
        drive(1, 32'hB3, 4'h5, 1, 1, 1);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("fl_occ0", occ, 0);
        chk("fl_after_valid", out_valid, 0);
        chk("fl_data_kept", out_data, 32'hB1);
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk("fl_flush_cnt", flush_cnt, 1);
`endif

        // Async reset between edges while full
        drive(1, 32'hC1, 4'h3, 0, 0, 0);
        drive(1, 32'hC2, 4'h3, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("ar_occ2", occ, 2);
        #1 rst = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_wen", out_wen, 0);
        chk("ar_occ", occ, 0);
        chk("ar_out_data", out_data, RD);
        chk("ar_in_ready", in_ready, 0);
        drive(1, 32'hC3, 4'h1, 1, 0, 0);
        chk("ar_in_ready_held", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ar_rel_in_ready", in_ready, 1);
        chk("ar_rel_occ", occ, 0);
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk("ar_flush_cnt", flush_cnt, 0);
        chk("ar_stall_cnt", stall_cnt, 0);
`endif

        // Random against a queue model
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic v, r, h, f;
            logic [DW-1:0] d;
            logic [WW-1:0] w;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            h = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 49) == 0);
            d = $urandom;
            w = 4'($urandom_range(0, 15));
            drive(v, d, w, r, h, f);
            ev_rdy = !h && !f && (q.size() < 2);
            ev_ov  = !h && !f && (q.size() > 0);
            chk("rnd_in_ready", in_ready, ev_rdy);
            chk("rnd_out_valid", out_valid, ev_ov);
            chk("rnd_occ", occ, q.size());
            if (ev_ov) begin
                chk("rnd_out_data", out_data, q[0][DW-1:0]);
                chk("rnd_out_wen", out_wen, q[0][DW+WW-1:DW]);
            end else begin
                chk("rnd_out_wen0", out_wen, 0);
            end
            if (f) begin
                q.delete();
            end else begin
                if (ev_ov && r) void'(q.pop_front());
                if (ev_rdy && v) q.push_back({w, d});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
